// File: rtl/twiddle_scheduler_pkg.sv
// Shared FFT constants, index typedefs and scheduler state encoding
// for the 64-point radix-2 twiddle scheduler.
package fft_pkg;
    localparam int LOG2_N     = 6;
    localparam int N          = 1 << LOG2_N;
    localparam int LANES      = 8;
    localparam int BEATS      = (N / 2) / LANES;
    localparam int NUM_STAGES = LOG2_N;

    typedef logic [LOG2_N-1:0] tw_idx_t;
    typedef logic [2:0]        stage_t;
    typedef logic [1:0]        beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } sched_state_t;
endpackage

// File: rtl/twiddle_scheduler_if.sv
// Command bus between FFT control, twiddle scheduler and butterfly datapath.
// TWIDDLE_INV_EN adds inv_i to request conjugate (inverse FFT) twiddles.
interface twiddle_scheduler_if;
    import fft_pkg::*;

    logic    start_i;
    logic    ready_i;
    tw_idx_t tw_start_o;
    tw_idx_t tw_step_o;
    stage_t  stage_o;
    beat_t   beat_o;
    logic    valid_o;
    logic    busy_o;
    logic    done_o;
`ifdef TWIDDLE_INV_EN
    logic    inv_i;

    modport master (
        input  start_i, ready_i, inv_i,
        output tw_start_o, tw_step_o, stage_o, beat_o, valid_o, busy_o, done_o
    );
    modport slave (
        output start_i, ready_i, inv_i,
        input  tw_start_o, tw_step_o, stage_o, beat_o, valid_o, busy_o, done_o
    );
`else
    modport master (
        input  start_i, ready_i,
        output tw_start_o, tw_step_o, stage_o, beat_o, valid_o, busy_o, done_o
    );
    modport slave (
        output start_i, ready_i,
        input  tw_start_o, tw_step_o, stage_o, beat_o, valid_o, busy_o, done_o
    );
`endif
endinterface

// File: rtl/twiddle_scheduler_addr_gen.sv
// Combinational map from (stage, beat, inv) to the LUT (start, step) pair.
// Early stages share one twiddle across lanes; late stages walk consecutive j.
module twiddle_addr_gen
    import fft_pkg::*;
(
    input  stage_t  stage_i,
    input  beat_t   beat_i,
    input  logic    inv_i,
    output tw_idx_t start_o,
    output tw_idx_t step_o
);
    tw_idx_t beat_ext;
    tw_idx_t lane_base;
    tw_idx_t mask;
    tw_idx_t start_raw;
    tw_idx_t step_raw;

    always_comb begin
        beat_ext  = tw_idx_t'(beat_i);
        lane_base = beat_ext * tw_idx_t'(LANES);
        mask      = (tw_idx_t'(1) << stage_i) - tw_idx_t'(1);
        if (stage_i < 3'd3) begin
            step_raw  = '0;
            start_raw = (beat_ext >> (3'd2 - stage_i)) << (3'd5 - stage_i);
        end else begin
            step_raw  = tw_idx_t'(1) << (3'd5 - stage_i);
            start_raw = (lane_base & mask) << (3'd5 - stage_i);
        end
        // Negation mod 64 gives the conjugate twiddle for the inverse transform.
        start_o = inv_i ? (tw_idx_t'(0) - start_raw) : start_raw;
        step_o  = inv_i ? (tw_idx_t'(0) - step_raw)  : step_raw;
    end
endmodule

// File: rtl/twiddle_scheduler.sv
// Walks 6 stages x 4 beats of twiddle commands over a valid/ready bus.
// TWIDDLE_INV_EN enables the inv_i conjugate-twiddle option.
//
// state | meaning
// IDLE  | waiting for start_i; loads stage 0 beat 0 on start
// RUN   | presents registered commands, advances on each accept
// FIN   | one-cycle done_o pulse, start_i ignored
module twiddle_scheduler
    import fft_pkg::*;
(
    input logic                 clk,
    input logic                 rst,
    twiddle_scheduler_if.master bus
);
    sched_state_t state_q, state_d;
    stage_t       stage_q, stage_d, stage_nxt;
    beat_t        beat_q, beat_d, beat_nxt;
    tw_idx_t      tw_start_q, tw_start_d, tw_step_q, tw_step_d;
    tw_idx_t      gen_start, gen_step;
    logic         valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic         inv_sel, last_beat;

`ifdef TWIDDLE_INV_EN
    logic inv_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == IDLE && bus.start_i) begin
            inv_q <= bus.inv_i;
        end
    end

    assign inv_sel = (state_q == IDLE) ? bus.inv_i : inv_q;
`else
    assign inv_sel = 1'b0;
`endif

    // Generator looks one command ahead so accepts stream without bubbles.
    always_comb begin
        beat_nxt  = beat_q + beat_t'(1);
        stage_nxt = (beat_q == beat_t'(BEATS - 1)) ? stage_q + stage_t'(1) : stage_q;
        if (state_q != RUN) begin
            beat_nxt  = '0;
            stage_nxt = '0;
        end
    end

    twiddle_addr_gen u_addr_gen (
        .stage_i (stage_nxt),
        .beat_i  (beat_nxt),
        .inv_i   (inv_sel),
        .start_o (gen_start),
        .step_o  (gen_step)
    );

    assign last_beat = (stage_q == stage_t'(NUM_STAGES - 1)) && (beat_q == beat_t'(BEATS - 1));

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        beat_d     = beat_q;
        tw_start_d = tw_start_q;
        tw_step_d  = tw_step_q;
        valid_d    = valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    state_d    = RUN;
                    stage_d    = '0;
                    beat_d     = '0;
                    tw_start_d = gen_start;
                    tw_step_d  = gen_step;
                end
            end
            RUN: begin
                if (!valid_q) begin
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.ready_i) begin
                    if (last_beat) begin
                        state_d = FIN;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stage_d    = stage_nxt;
                        beat_d     = beat_nxt;
                        tw_start_d = gen_start;
                        tw_step_d  = gen_step;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            stage_q    <= '0;
            beat_q     <= '0;
            tw_start_q <= '0;
            tw_step_q  <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            beat_q     <= beat_d;
            tw_start_q <= tw_start_d;
            tw_step_q  <= tw_step_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tw_start_o = tw_start_q;
    assign bus.tw_step_o  = tw_step_q;
    assign bus.stage_o    = stage_q;
    assign bus.beat_o     = beat_q;
    assign bus.valid_o    = valid_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
endmodule

// File: tb/tb_twiddle_scheduler.sv
// Bench for twiddle_scheduler: reference twiddle table, random backpressure,
// directed reset/restart/backpressure steps; inv runs when TWIDDLE_INV_EN is set.
module tb_twiddle_scheduler;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    twiddle_scheduler_if bus ();

    twiddle_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Forward twiddle table: start index per (stage, beat), step per stage.
    int exp_start_tbl [6][4] = '{'{0, 0, 0, 0}, '{0, 0, 16, 16}, '{0, 8, 16, 24},
                                 '{0, 0, 0, 0}, '{0, 16, 0, 16}, '{0, 8, 16, 24}};
    int exp_step_tbl [6] = '{0, 0, 0, 4, 2, 1};

    function automatic int conj(input int x, input bit inv);
        return inv ? ((64 - x) % 64) : x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: random ready, 1: ready high, 2: 5-cycle stall at stage4 beat1,
    // 3: stray start during stage 2, 4: ready high and start on the done cycle.
    task automatic run_sched(input int mode, input bit inv);
        int idx = 0;
        int done_cnt = 0;
        int done_cyc = -1;
        int first_valid = -1;
        int hold = 0;
        bit restarted = 1'b0;
        bit finished = 1'b0;
        int s;
        int b;
        bus.start_i = 1'b1;
`ifdef TWIDDLE_INV_EN
        bus.inv_i = inv;
`endif
        bus.ready_i = 1'b1;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
`ifdef TWIDDLE_INV_EN
            bus.inv_i = ~inv;
`endif
            if (bus.done_o) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_valid", 32'(bus.valid_o), 0);
                chk("done_busy", 32'(bus.busy_o), 0);
                if (mode == 4) bus.start_i = 1'b1;
                @(negedge clk);
                bus.start_i = 1'b0;
                chk("done_width", 32'(bus.done_o), 0);
                finished = 1'b1;
            end else if (bus.valid_o) begin
                if (first_valid < 0) first_valid = cyc;
                s = idx / BEATS;
                b = idx % BEATS;
                if (idx >= 24) begin
                    chk("extra_beat", 32'(idx), 23);
                    s = 5;
                    b = 3;
                end
                chk("stage", 32'(bus.stage_o), 32'(s));
                chk("beat", 32'(bus.beat_o), 32'(b));
                chk("tw_start", 32'(bus.tw_start_o), 32'(conj(exp_start_tbl[s][b], inv)));
                chk("tw_step", 32'(bus.tw_step_o), 32'(conj(exp_step_tbl[s], inv)));
                chk("busy_run", 32'(bus.busy_o), 1);
                if (inv && idx == 21) begin
                    chk("inv_s5b1_start", 32'(bus.tw_start_o), 56);
                    chk("inv_s5b1_step", 32'(bus.tw_step_o), 63);
                end
                if (inv && idx == 12) begin
                    chk("inv_s3b0_start", 32'(bus.tw_start_o), 0);
                    chk("inv_s3b0_step", 32'(bus.tw_step_o), 60);
                end
                case (mode)
                    0: bus.ready_i = 1'($urandom_range(0, 1));
                    2: begin
                        if (idx == 17 && hold < 5) begin
                            chk("stall_start", 32'(bus.tw_start_o), 16);
                            chk("stall_step", 32'(bus.tw_step_o), 2);
                            bus.ready_i = 1'b0;
                            hold++;
                        end else begin
                            bus.ready_i = 1'b1;
                        end
                    end
                    3: begin
                        if (idx == 9 && !restarted) begin
                            bus.start_i = 1'b1;
                            restarted = 1'b1;
                        end
                        bus.ready_i = 1'b1;
                    end
                    default: bus.ready_i = 1'b1;
                endcase
                if (bus.ready_i) idx++;
            end else if (mode == 0) begin
                bus.ready_i = 1'($urandom_range(0, 1));
            end
        end
        bus.ready_i = 1'b1;
        chk("beats_accepted", 32'(idx), 24);
        chk("done_count", 32'(done_cnt), 1);
        if (mode == 2) chk("stall_cycles", 32'(hold), 5);
        if (mode == 1 || mode == 4) begin
            chk("first_valid_latency", 32'(first_valid), 2);
            chk("done_latency", 32'(done_cyc), 26);
        end
    endtask

    initial begin
        bit found;
        int done_seen;
        int valid_seen;
        rst = 1'b1;
        bus.start_i = 1'b0;
        bus.ready_i = 1'b0;
`ifdef TWIDDLE_INV_EN
        bus.inv_i = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(bus.valid_o), 0);
        chk("rst_busy", 32'(bus.busy_o), 0);
        chk("rst_done", 32'(bus.done_o), 0);
        chk("rst_start", 32'(bus.tw_start_o), 0);
        chk("rst_step", 32'(bus.tw_step_o), 0);
        chk("rst_stage", 32'(bus.stage_o), 0);
        chk("rst_beat", 32'(bus.beat_o), 0);
        rst = 1'b0;
        @(negedge clk);

        run_sched(1, 1'b0);
        run_sched(1, 1'b0);
        run_sched(2, 1'b0);
        run_sched(3, 1'b0);
        run_sched(4, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("ignored_start_valid", 32'(bus.valid_o), 0);
            chk("ignored_start_busy", 32'(bus.busy_o), 0);
        end
        repeat (3) run_sched(0, 1'b0);

        found = 1'b0;
        bus.start_i = 1'b1;
        bus.ready_i = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
            if (bus.valid_o && bus.stage_o == 3'd3 && bus.beat_o == 2'd1) found = 1'b1;
        end
        chk("reach_s3b1", 32'(found), 1);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.valid_o), 0);
        chk("midrst_busy", 32'(bus.busy_o), 0);
        chk("midrst_start", 32'(bus.tw_start_o), 0);
        chk("midrst_step", 32'(bus.tw_step_o), 0);
        chk("midrst_stage", 32'(bus.stage_o), 0);
        @(posedge clk);
        #1;
        chk("midrst_next_valid", 32'(bus.valid_o), 0);
        chk("midrst_next_busy", 32'(bus.busy_o), 0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        valid_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o) done_seen++;
            if (bus.valid_o) valid_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 0);
        chk("midrst_idle", 32'(valid_seen), 0);
        run_sched(1, 1'b0);
        run_sched(0, 1'b0);
`ifdef TWIDDLE_INV_EN
        run_sched(1, 1'b1);
        run_sched(0, 1'b1);
        run_sched(1, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
